// File: rtl/neureka_tcdm_responder_if.sv
// TCDM port bundle between the NEUREKA initiator and a memory responder.
// MP parallel 32-bit ports; each carries a request/grant handshake, a byte
// address, read/write select (wen=1 read), byte enables, write data, and a
// one-cycle-later response (r_valid/r_data).
//   master : initiator side (drives req/add/wen/be/data)
//   slave  : responder side (drives gnt/r_data/r_valid)
interface neureka_tcdm_responder_if #(
  parameter int unsigned MP = 9
);
  logic [MP-1:0] req;
  logic [MP-1:0] gnt;
  logic [31:0]   add    [MP];
  logic [MP-1:0] wen;
  logic [3:0]    be     [MP];
  logic [31:0]   data   [MP];
  logic [31:0]   r_data [MP];
  logic [MP-1:0] r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/neureka_tcdm_responder.sv
// Word-interleaved multi-bank TCDM scratchpad acting as responder for MP
// 32-bit ports. Each bank arbitrates its eligible requesters round-robin,
// reads return one cycle after grant, writes are byte-enabled.
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset (memory array not reset)
//   clear_i        synchronous clear of pointers, counter and responses
//   stall_i[MP]    force grant denial on a port
//   conflict_cnt_o saturating count of cycles with an ungranted request
//   tcdm           slave end of the TCDM port bundle
module neureka_tcdm_responder #(
  parameter int unsigned MP         = 9,
  parameter int unsigned NB         = 16,
  parameter int unsigned BANK_WORDS = 256,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [MP-1:0]       stall_i,
  output logic [CNT_W-1:0]    conflict_cnt_o,
  neureka_tcdm_responder_if.slave tcdm
);

  localparam int unsigned BB = $clog2(NB);
  localparam int unsigned WW = $clog2(NB * BANK_WORDS);
  localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;

  logic [31:0]      r_mem   [NB*BANK_WORDS];
  logic [PW-1:0]    r_ptr   [NB];
  logic [31:0]      r_rdata [MP];
  logic [MP-1:0]    r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [WW-1:0]    w_widx    [MP];
  logic [BB-1:0]    w_bank    [MP];
  logic [PW-1:0]    w_ptr_nxt [NB];
  logic [MP-1:0]    w_elig;
  logic [MP-1:0]    w_gnt;
  logic [NB-1:0]    w_bank_gnt;
  logic             w_conflict;
  logic             w_unused_addr;

  // With NB a power of two, {row, bank} is simply the low WW bits of the
  // word address, so the memory is one flat array indexed by them.
  always_comb begin
    w_unused_addr = 1'b0;
    for (int unsigned p = 0; p < MP; p++) begin
      w_widx[p]     = tcdm.add[p][2 +: WW];
      w_bank[p]     = w_widx[p][BB-1:0];
      w_unused_addr = w_unused_addr ^ (^tcdm.add[p]);
    end
  end

  assign w_elig = tcdm.req & ~stall_i;

  // Per bank: scan ports starting at the bank pointer; first eligible
  // requester targeting this bank wins.
  always_comb begin
    w_gnt      = '0;
    w_bank_gnt = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      w_ptr_nxt[b] = r_ptr[b];
      for (int unsigned k = 0; k < MP; k++) begin
        int unsigned p;
        p = int'(r_ptr[b]) + k;
        if (p >= MP) p = p - MP;
        if (w_elig[p] && (w_bank[p] == BB'(b)) && !w_bank_gnt[b]) begin
          w_bank_gnt[b] = 1'b1;
          w_gnt[p]      = 1'b1;
          w_ptr_nxt[b]  = PW'((p + 1) % MP);
        end
      end
    end
  end

  assign w_conflict = |(tcdm.req & ~w_gnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < NB; b++) r_ptr[b] <= '0;
    end else if (clear_i) begin
      for (int unsigned b = 0; b < NB; b++) r_ptr[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NB; b++) r_ptr[b] <= w_ptr_nxt[b];
    end
  end

  // Memory is retained across reset; writes commit even during clear.
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < MP; p++) begin
      if (w_gnt[p] && !tcdm.wen[p]) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (tcdm.be[p][i]) r_mem[w_widx[p]][8*i +: 8] <= tcdm.data[p][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int unsigned p = 0; p < MP; p++) r_rdata[p] <= '0;
    end else if (clear_i) begin
      r_valid <= '0;
      for (int unsigned p = 0; p < MP; p++) r_rdata[p] <= '0;
    end else begin
      r_valid <= w_gnt;
      for (int unsigned p = 0; p < MP; p++) begin
        if (w_gnt[p]) r_rdata[p] <= tcdm.wen[p] ? r_mem[w_widx[p]] : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tcdm.gnt       = w_gnt;
  assign tcdm.r_valid   = r_valid;
  assign tcdm.r_data    = r_rdata;
  assign conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
module tb_neureka_tcdm_responder;
  localparam int unsigned MP    = 9;
  localparam int unsigned NB    = 16;
  localparam int unsigned BW    = 256;
  localparam int unsigned CNT_W = 32;

  logic             clk    = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear  = 1'b0;
  logic [MP-1:0]    stall  = '0;
  logic [CNT_W-1:0] cnt;

  int n_checks = 0;
  int n_err    = 0;

  neureka_tcdm_responder_if #(.MP(MP)) tcdm ();

  neureka_tcdm_responder #(
    .MP(MP), .NB(NB), .BANK_WORDS(BW), .CNT_W(CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clear_i       (clear),
    .stall_i       (stall),
    .conflict_cnt_o(cnt),
    .tcdm          (tcdm)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_ptr [NB];
  logic [MP-1:0] m_rv;
  logic [31:0]   m_rd  [MP];
  bit            m_rdk [MP];
  logic [31:0]   m_cnt;
  logic [31:0]   m_mem [int unsigned];

  function automatic int unsigned word_of(logic [31:0] a);
    return (int'(a) >>> 2) % (NB * BW);
  endfunction

  always @(negedge clk) begin : model
    int win [NB];
    int bd  [NB];
    logic [MP-1:0] eg;
    logic [31:0] new_rd [MP];
    bit new_k [MP];
    int unsigned w, b, d;
    if (!rst_ni) begin
      for (int i = 0; i < NB; i++) m_ptr[i] = 0;
      m_rv = '0; m_cnt = '0;
      for (int p = 0; p < MP; p++) begin m_rd[p] = '0; m_rdk[p] = 1; end
      chk("reset_rvalid", tcdm.r_valid, '0);
      chk("reset_cnt", cnt, '0);
    end else begin
      chk("rvalid", tcdm.r_valid, m_rv);
      for (int p = 0; p < MP; p++) if (m_rdk[p]) chk("rdata", tcdm.r_data[p], m_rd[p]);
      chk("cnt", cnt, m_cnt);
      // winner per bank = eligible requester closest after the pointer
      for (int i = 0; i < NB; i++) begin win[i] = -1; bd[i] = MP; end
      for (int p = 0; p < MP; p++) begin
        if (tcdm.req[p] && !stall[p]) begin
          w = word_of(tcdm.add[p]);
          b = w % NB;
          d = (p + MP - m_ptr[b]) % MP;
          if (win[b] < 0 || d < bd[b]) begin win[b] = p; bd[b] = d; end
        end
      end
      eg = '0;
      for (int i = 0; i < NB; i++) if (win[i] >= 0) eg[win[i]] = 1'b1;
      chk("gnt", tcdm.gnt, eg);
      // responses from memory as it was before this cycle's writes
      for (int p = 0; p < MP; p++) begin
        new_rd[p] = m_rd[p]; new_k[p] = m_rdk[p];
        if (eg[p]) begin
          if (!tcdm.wen[p]) begin new_rd[p] = '0; new_k[p] = 1; end
          else begin
            w = word_of(tcdm.add[p]);
            new_k[p] = m_mem.exists(w);
            new_rd[p] = new_k[p] ? m_mem[w] : '0;
          end
        end
      end
      for (int p = 0; p < MP; p++) begin
        if (eg[p] && !tcdm.wen[p]) begin
          w = word_of(tcdm.add[p]);
          if (m_mem.exists(w)) begin
            for (int i = 0; i < 4; i++)
              if (tcdm.be[p][i]) m_mem[w][8*i +: 8] = tcdm.data[p][8*i +: 8];
          end else if (tcdm.be[p] == 4'hF) begin
            m_mem[w] = tcdm.data[p];
          end
        end
      end
      if (clear) begin
        m_rv = '0; m_cnt = '0;
        for (int p = 0; p < MP; p++) begin m_rd[p] = '0; m_rdk[p] = 1; end
        for (int i = 0; i < NB; i++) m_ptr[i] = 0;
      end else begin
        m_rv = eg;
        for (int p = 0; p < MP; p++) begin m_rd[p] = new_rd[p]; m_rdk[p] = new_k[p]; end
        if (|(tcdm.req & ~eg) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        for (int i = 0; i < NB; i++) if (win[i] >= 0) m_ptr[i] = (win[i] + 1) % MP;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    tcdm.req = '0;
    tcdm.wen = '1;
    for (int p = 0; p < MP; p++) begin
      tcdm.add[p] = '0; tcdm.be[p] = '0; tcdm.data[p] = '0;
    end
  endtask

  task automatic drv(int p, logic [31:0] a, logic w, logic [3:0] be, logic [31:0] d);
    tcdm.req[p] = 1'b1; tcdm.add[p] = a; tcdm.wen[p] = w;
    tcdm.be[p] = be; tcdm.data[p] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    idle(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    chk("lit_reset_rvalid", tcdm.r_valid, '0);
    chk("lit_reset_cnt", cnt, '0);
    chk("lit_reset_rdata0", tcdm.r_data[0], '0);

    // contiguous write then read, all banks distinct
    for (int p = 0; p < MP; p++) drv(p, 32'(4*p), 1'b0, 4'hF, 32'hA0 + p);
    #1 chk("lit_wr_gnt", tcdm.gnt, 9'h1FF);
    tick();
    for (int p = 0; p < MP; p++) drv(p, 32'(4*p), 1'b1, 4'h0, '0);
    #1 chk("lit_rd_gnt", tcdm.gnt, 9'h1FF);
    tick(); idle();
    #1 chk("lit_rd_rvalid", tcdm.r_valid, 9'h1FF);
    for (int p = 0; p < MP; p++) chk("lit_rd_data", tcdm.r_data[p], 32'hA0 + p);

    // bank 0 conflict among ports 0,1,2
    pulse_clear();
    for (int p = 0; p < 3; p++) drv(p, 32'h40, 1'b1, 4'h0, '0);
    #1 chk("lit_conf_g0", tcdm.gnt, 9'h001);
    tick(); tcdm.req[0] = 1'b0;
    #1 chk("lit_conf_g1", tcdm.gnt, 9'h002);
    tick(); tcdm.req[1] = 1'b0;
    #1 chk("lit_conf_g2", tcdm.gnt, 9'h004);
    tick(); idle();
    drv(2, 32'h40, 1'b1, 4'h0, '0); drv(4, 32'h40, 1'b1, 4'h0, '0);
    #1 chk("lit_conf_cnt", cnt, 32'd2);
    chk("lit_conf_ptr3", tcdm.gnt, 9'h010);
    tick(); idle();

    // byte enables
    drv(0, 32'h100, 1'b0, 4'hF, 32'hFFFF_FFFF); tick();
    drv(0, 32'h100, 1'b0, 4'b0101, 32'h1234_5678); tick();
    drv(0, 32'h100, 1'b1, 4'h0, '0); tick(); idle();
    #1 chk("lit_be_data", tcdm.r_data[0], 32'hFF34_FF78);

    // stall injection on port 4
    pulse_clear();
    for (int p = 0; p < MP; p++) drv(p, 32'(4*p), 1'b1, 4'h0, '0);
    stall = 9'h010;
    #1 chk("lit_stall_gnt_a", tcdm.gnt, 9'h1EF);
    tick();
    #1 chk("lit_stall_gnt_b", tcdm.gnt, 9'h1EF);
    tick(); idle(); stall = '0;
    drv(4, 32'h10, 1'b1, 4'h0, '0);
    #1 chk("lit_stall_cnt", cnt, 32'd2);
    chk("lit_stall_release", tcdm.gnt, 9'h010);
    tick(); idle();
    #1 chk("lit_stall_rvalid", tcdm.r_valid, 9'h010);
    chk("lit_stall_rdata", tcdm.r_data[4], 32'hA4);

    // address wrap
    drv(0, 32'h0, 1'b0, 4'hF, 32'h0000_DEAD); tick();
    drv(0, 32'h4000, 1'b1, 4'h0, '0); tick(); idle();
    #1 chk("lit_wrap", tcdm.r_data[0], 32'h0000_DEAD);

    // asynchronous reset with a response outstanding
    drv(0, 32'h4, 1'b1, 4'h0, '0); tick(); idle();
    #1 chk("lit_pre_rst_rvalid", tcdm.r_valid, 9'h001);
    rst_ni = 1'b0;
    #1 chk("lit_async_rst_rvalid", tcdm.r_valid, '0);
    tick(); tick(); rst_ni = 1'b1;
    drv(0, 32'h8, 1'b1, 4'h0, '0); tick(); idle();
    #1 chk("lit_retain_rvalid", tcdm.r_valid, 9'h001);
    chk("lit_retain_data", tcdm.r_data[0], 32'hA2);

    // counter to 5, then clear zeroes counter and pointers
    pulse_clear();
    drv(1, 32'h40, 1'b1, 4'h0, '0); drv(0, 32'h80, 1'b1, 4'h0, '0);
    stall = 9'h001;
    repeat (5) tick();
    chk("lit_cnt5", cnt, 32'd5);
    idle(); stall = '0; clear = 1'b1;
    tick(); clear = 1'b0;
    chk("lit_clear_cnt", cnt, '0);
    drv(1, 32'h40, 1'b1, 4'h0, '0); drv(2, 32'h40, 1'b1, 4'h0, '0);
    #1 chk("lit_clear_ptr", tcdm.gnt, 9'h002);
    tick(); idle();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
